// File: rtl/pipefft_pkg.sv
// Shared types and default widths for the pipelined FFT stages.
//   IN_W_DEF / OUT_W_DEF : default sample widths (output carries one bit of growth)
//   state_t              : butterfly stage phase
//   cplx_t               : {im, re} complex word as stored in the delay-line RAM
package pipefft_pkg;

   localparam int unsigned IN_W_DEF  = 32;
   localparam int unsigned OUT_W_DEF = 33;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      BFLY = 2'd2
   } state_t;

   typedef struct packed {
      logic signed [OUT_W_DEF-1:0] im;
      logic signed [OUT_W_DEF-1:0] re;
   } cplx_t;

endpackage

// File: rtl/pipefft_bfly2.sv
// Combinational radix-2 butterfly on a complex pair: sum = a+b, dif = a-b.
// Real and imaginary parts are independent.
// With PIPEFFT_BFLY_SCALE_EN defined, both results are computed one bit wider
// and arithmetic-shifted right by 1 (rounding toward minus infinity).
// Ports:
//   a_re, a_im, b_re, b_im     : signed W-bit operands
//   sum_re, sum_im             : a+b (optionally halved)
//   dif_re, dif_im             : a-b (optionally halved)
module pipefft_bfly2
   import pipefft_pkg::*;
#(
   parameter int unsigned W = OUT_W_DEF
) (
   input  logic signed [W-1:0] a_re,
   input  logic signed [W-1:0] a_im,
   input  logic signed [W-1:0] b_re,
   input  logic signed [W-1:0] b_im,
   output logic signed [W-1:0] sum_re,
   output logic signed [W-1:0] sum_im,
   output logic signed [W-1:0] dif_re,
   output logic signed [W-1:0] dif_im
);

`ifdef PIPEFFT_BFLY_SCALE_EN
   logic signed [W:0] s_re, s_im, d_re, d_im;

   // Widen by one bit so the halved result is exact before truncation.
   always_comb begin
      s_re   = (W+1)'(a_re) + (W+1)'(b_re);
      s_im   = (W+1)'(a_im) + (W+1)'(b_im);
      d_re   = (W+1)'(a_re) - (W+1)'(b_re);
      d_im   = (W+1)'(a_im) - (W+1)'(b_im);
      sum_re = W'(s_re >>> 1);
      sum_im = W'(s_im >>> 1);
      dif_re = W'(d_re >>> 1);
      dif_im = W'(d_im >>> 1);
   end
`else
   // Full precision: the caller's one bit of headroom absorbs the growth.
   always_comb begin
      sum_re = a_re + b_re;
      sum_im = a_im + b_im;
      dif_re = a_re - b_re;
      dif_im = a_im - b_im;
   end
`endif

endmodule

// File: rtl/pipefft_r2sdf_bfly.sv
// R2SDF butterfly stage controller: drives a DLY-entry delay-line RAM,
// performs the add/subtract butterfly and the FILL/BFLY commutation.
// Optional feature macro: PIPEFFT_BFLY_SCALE_EN (halve BFLY sum/difference).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid, in_sop         : input strobe, first-sample-of-frame flag
//   in_re, in_im             : signed IN_W input sample
//   out_valid, out_sop       : registered output strobe, first butterfly sum
//   out_re, out_im           : signed OUT_W output sample
//   frame_err                : one-cycle pulse when in_sop arrives off-boundary
//   ram_wD, ram_wAddr, ram_wEn : RAM write port, {im, re} word
//   ram_rAddr, ram_rD        : RAM read port; ram_rD must reflect the word at
//                              the registered ram_rAddr (data for the next sample)
module pipefft_r2sdf_bfly
   import pipefft_pkg::*;
#(
   parameter int unsigned DLY   = 2,
   parameter int unsigned IN_W  = IN_W_DEF,
   parameter int unsigned OUT_W = OUT_W_DEF,
   parameter int unsigned AW    = $clog2(DLY)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_sop,
   input  logic signed [IN_W-1:0]  in_re,
   input  logic signed [IN_W-1:0]  in_im,
   output logic                    out_valid,
   output logic                    out_sop,
   output logic signed [OUT_W-1:0] out_re,
   output logic signed [OUT_W-1:0] out_im,
   output logic                    frame_err,
   output logic [2*OUT_W-1:0]      ram_wD,
   output logic [AW-1:0]           ram_wAddr,
   output logic [AW-1:0]           ram_rAddr,
   output logic                    ram_wEn,
   input  logic [2*OUT_W-1:0]      ram_rD
);

   localparam int unsigned CW = $clog2(2*DLY);

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d, cnt_eff_c;
   logic [AW-1:0]           wp_q, wp_d;
   logic                    primed_q, primed_d;
   logic                    bfly_c, sop_err_c;

   logic signed [OUT_W-1:0] a_re_c, a_im_c, b_re_c, b_im_c;
   logic signed [OUT_W-1:0] sum_re_c, sum_im_c, dif_re_c, dif_im_c;

   logic                    out_valid_d, out_sop_d, frame_err_d, ram_wEn_d;
   logic signed [OUT_W-1:0] out_re_d, out_im_d;
   logic [2*OUT_W-1:0]      ram_wD_d;
   logic [AW-1:0]           ram_wAddr_d, ram_rAddr_d;

   // Operand unpacking: a from the delay line, b is the sign-extended input.
   always_comb begin
      a_re_c = ram_rD[OUT_W-1:0];
      a_im_c = ram_rD[2*OUT_W-1:OUT_W];
      b_re_c = OUT_W'(in_re);
      b_im_c = OUT_W'(in_im);
   end

   pipefft_bfly2 #(.W(OUT_W)) u_bfly2 (
      .a_re   (a_re_c),
      .a_im   (a_im_c),
      .b_re   (b_re_c),
      .b_im   (b_im_c),
      .sum_re (sum_re_c),
      .sum_im (sum_im_c),
      .dif_re (dif_re_c),
      .dif_im (dif_im_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wp_d        = wp_q;
      primed_d    = primed_q;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      frame_err_d = 1'b0;
      out_re_d    = out_re;
      out_im_d    = out_im;
      ram_wD_d    = ram_wD;
      ram_wAddr_d = ram_wAddr;
      ram_rAddr_d = ram_rAddr;
      ram_wEn_d   = in_valid;

      // in_sop realigns the frame; the sample it marks is always a FILL sample.
      cnt_eff_c = in_sop ? '0 : cnt_q;
      sop_err_c = in_valid && in_sop && (cnt_q != '0);
      bfly_c    = (state_q == BFLY) && !in_sop;

      if (in_valid) begin
         cnt_d       = cnt_eff_c + CW'(1);
         state_d     = cnt_d[CW-1] ? BFLY : FILL;
         wp_d        = wp_q + AW'(1);
         // Reading wp+1 returns the word written DLY accepted samples earlier.
         ram_wAddr_d = wp_q;
         ram_rAddr_d = wp_q + AW'(1);
         out_sop_d   = (cnt_eff_c == CW'(DLY));
         frame_err_d = sop_err_c;

         if (bfly_c) begin
            out_valid_d = 1'b1;
            primed_d    = 1'b1;
            out_re_d    = sum_re_c;
            out_im_d    = sum_im_c;
            ram_wD_d    = {dif_im_c, dif_re_c};
         end else begin
            // Differences in the RAM are stale after a resync, so drop them.
            out_valid_d = primed_q && !sop_err_c;
            if (sop_err_c) begin
               primed_d = 1'b0;
            end
            out_re_d    = a_re_c;
            out_im_d    = a_im_c;
            ram_wD_d    = {b_im_c, b_re_c};
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath, pointer and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         wp_q      <= '0;
         primed_q  <= 1'b0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         frame_err <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         ram_wD    <= '0;
         ram_wAddr <= '0;
         ram_rAddr <= '0;
         ram_wEn   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         wp_q      <= wp_d;
         primed_q  <= primed_d;
         out_valid <= out_valid_d;
         out_sop   <= out_sop_d;
         frame_err <= frame_err_d;
         out_re    <= out_re_d;
         out_im    <= out_im_d;
         ram_wD    <= ram_wD_d;
         ram_wAddr <= ram_wAddr_d;
         ram_rAddr <= ram_rAddr_d;
         ram_wEn   <= ram_wEn_d;
      end
   end

endmodule

// File: tb/tb_pipefft_r2sdf_bfly.sv
// Directed bench for pipefft_r2sdf_bfly (DLY=2) with a behavioural delay-line RAM.
module tb_pipefft_r2sdf_bfly;
   import pipefft_pkg::*;

   localparam int unsigned DLY   = 2;
   localparam int unsigned IN_W  = 32;
   localparam int unsigned OUT_W = 33;
   localparam int unsigned AW    = 1;
   localparam longint      MAXP  = 64'sd2147483647;
   localparam longint      MINN  = -64'sd2147483648;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid, in_sop;
   logic signed [IN_W-1:0]  in_re, in_im;
   logic                    out_valid, out_sop, frame_err;
   logic signed [OUT_W-1:0] out_re, out_im;
   logic [2*OUT_W-1:0]      ram_wD, ram_rD;
   logic [AW-1:0]           ram_wAddr, ram_rAddr;
   logic                    ram_wEn;

   logic [2*OUT_W-1:0]      mem [DLY];
   logic                    mon_en   = 1'b0;
   logic                    prev_v   = 1'b0;
   logic                    acc_seen = 1'b0;
   cplx_t                   w;
   int                      n_cmp = 0;
   int                      n_err = 0;

   always #5 clk = ~clk;

   pipefft_r2sdf_bfly #(.DLY(DLY), .IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sop    (in_sop),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_sop   (out_sop),
      .out_re    (out_re),
      .out_im    (out_im),
      .frame_err (frame_err),
      .ram_wD    (ram_wD),
      .ram_wAddr (ram_wAddr),
      .ram_rAddr (ram_rAddr),
      .ram_wEn   (ram_wEn),
      .ram_rD    (ram_rD)
   );

   // Delay-line RAM: synchronous write, read word follows the registered read address.
   always @(posedge clk) if (ram_wEn) mem[ram_wAddr] <= ram_wD;
   assign ram_rD = mem[ram_rAddr];

   function automatic longint scl(input longint x);
`ifdef PIPEFFT_BFLY_SCALE_EN
      return x >>> 1;
`else
      return x;
`endif
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic s, input longint re, input longint im);
      in_valid = v;
      in_sop   = s;
      in_re    = IN_W'(re);
      in_im    = IN_W'(im);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic sp,
                             input longint re, input longint im);
      check({tag, ".valid"}, longint'(out_valid), longint'(v));
      check({tag, ".sop"}, longint'(out_sop), longint'(sp));
      if (v) begin
         check({tag, ".re"}, longint'(out_re), re);
         check({tag, ".im"}, longint'(out_im), im);
      end
   endtask

   // RAM-port monitor: write enable mirrors accepted samples, addresses never collide.
   always @(posedge clk) begin
      prev_v   <= rst ? 1'b0 : in_valid;
      acc_seen <= rst ? 1'b0 : (acc_seen | in_valid);
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("ram_wEn_mirror", longint'(ram_wEn), longint'(prev_v));
         if (acc_seen) check("raddr_ne_waddr", longint'(ram_rAddr != ram_wAddr), 1);
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_re = '0; in_im = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_valid", longint'(out_valid), 0);
      check("rst.out_sop", longint'(out_sop), 0);
      check("rst.frame_err", longint'(frame_err), 0);
      check("rst.out_re", longint'(out_re), 0);
      check("rst.out_im", longint'(out_im), 0);
      check("rst.ram_wEn", longint'(ram_wEn), 0);
      check("rst.ram_wD_zero", longint'(ram_wD == '0), 1);
      check("rst.ram_wAddr", longint'(ram_wAddr), 0);
      check("rst.ram_rAddr", longint'(ram_rAddr), 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Two back-to-back frames.
      step(1, 1, 1, 0); expect_out("t1.s1", 0, 0, 0, 0);
      check("t1.s1.frame_err", longint'(frame_err), 0);
      w = ram_wD;
      check("t1.s1.wD_re", longint'(w.re), 1);
      check("t1.s1.wAddr", longint'(ram_wAddr), 0);
      check("t1.s1.rAddr", longint'(ram_rAddr), 1);
      step(1, 0, 2, 0); expect_out("t1.s2", 0, 0, 0, 0);
      step(1, 0, 3, 0); expect_out("t1.s3", 1, 1, scl(4), 0);
      w = ram_wD;
      check("t1.s3.wD_re", longint'(w.re), scl(-2));
      step(1, 0, 4, 0); expect_out("t1.s4", 1, 0, scl(6), 0);
      step(1, 1, 5, 0); expect_out("t1.s5", 1, 0, scl(-2), 0);
      check("t1.s5.frame_err", longint'(frame_err), 0);
      step(1, 0, 6, 0); expect_out("t1.s6", 1, 0, scl(-2), 0);
      step(1, 0, 7, 0); expect_out("t1.s7", 1, 1, scl(12), 0);
      step(1, 0, 8, 0); expect_out("t1.s8", 1, 0, scl(14), 0);

      // Reset, then the same frames with one idle cycle after every sample.
      rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      step(1, 1, 1, 0); expect_out("t2.s1", 0, 0, 0, 0);
      step(0, 0, 0, 0); expect_out("t2.g1", 0, 0, 0, 0);
      check("t2.g1.wAddr_hold", longint'(ram_wAddr), 0);
      check("t2.g1.rAddr_hold", longint'(ram_rAddr), 1);
      step(1, 0, 2, 0); expect_out("t2.s2", 0, 0, 0, 0);
      step(0, 0, 0, 0); expect_out("t2.g2", 0, 0, 0, 0);
      step(1, 0, 3, 0); expect_out("t2.s3", 1, 1, scl(4), 0);
      step(0, 0, 0, 0); expect_out("t2.g3", 0, 0, 0, 0);
      step(1, 0, 4, 0); expect_out("t2.s4", 1, 0, scl(6), 0);
      step(0, 0, 0, 0); expect_out("t2.g4", 0, 0, 0, 0);
      step(1, 1, 5, 0); expect_out("t2.s5", 1, 0, scl(-2), 0);
      step(0, 0, 0, 0); expect_out("t2.g5", 0, 0, 0, 0);
      step(1, 0, 6, 0); expect_out("t2.s6", 1, 0, scl(-2), 0);
      step(0, 0, 0, 0); expect_out("t2.g6", 0, 0, 0, 0);
      step(1, 0, 7, 0); expect_out("t2.s7", 1, 1, scl(12), 0);
      step(0, 0, 0, 0); expect_out("t2.g7", 0, 0, 0, 0);
      step(1, 0, 8, 0); expect_out("t2.s8", 1, 0, scl(14), 0);
      step(0, 0, 0, 0); expect_out("t2.g8", 0, 0, 0, 0);

      // Off-boundary in_sop: error pulse, suppressed outputs, resync.
      step(1, 1, 10, 0); expect_out("t3.s1", 1, 0, scl(-2), 0);
      check("t3.s1.frame_err", longint'(frame_err), 0);
      step(1, 1, 20, 0); expect_out("t3.err", 0, 0, 0, 0);
      check("t3.err.frame_err", longint'(frame_err), 1);
      step(1, 0, 30, 0); expect_out("t3.s3", 0, 0, 0, 0);
      check("t3.s3.frame_err", longint'(frame_err), 0);
      step(1, 0, 40, 0); expect_out("t3.s4", 1, 1, scl(60), 0);
      step(1, 0, 50, 0); expect_out("t3.s5", 1, 0, scl(80), 0);

      // Reset in the middle of a BFLY phase, then a clean restart.
      step(1, 1, 1, 0); expect_out("t4.s1", 1, 0, scl(-20), 0);
      step(1, 0, 2, 0); expect_out("t4.s2", 1, 0, scl(-20), 0);
      step(1, 0, 3, 0); expect_out("t4.s3", 1, 1, scl(4), 0);
      rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
      @(posedge clk); #1;
      expect_out("t4.rst", 0, 0, 0, 0);
      check("t4.rst.wAddr", longint'(ram_wAddr), 0);
      rst = 1'b0;
      step(1, 1, 1, 0); expect_out("t4.r1", 0, 0, 0, 0);
      check("t4.r1.frame_err", longint'(frame_err), 0);
      step(1, 0, 2, 0); expect_out("t4.r2", 0, 0, 0, 0);
      step(1, 0, 3, 0); expect_out("t4.r3", 1, 1, scl(4), 0);
      step(1, 0, 4, 0); expect_out("t4.r4", 1, 0, scl(6), 0);

      // Extremes and independent imaginary path.
      step(1, 1, MAXP, MINN); expect_out("t5.s1", 1, 0, scl(-2), 0);
      step(1, 0, 0, 0);       expect_out("t5.s2", 1, 0, scl(-2), 0);
      step(1, 0, MAXP, MINN); expect_out("t5.s3", 1, 1, scl(2 * MAXP), scl(2 * MINN));
      check("t5.s3.wD_zero", longint'(ram_wD == '0), 1);
      step(1, 0, 5, -7);      expect_out("t5.s4", 1, 0, scl(5), scl(-7));
      step(1, 1, 0, 0);       expect_out("t5.s5", 1, 0, 0, 0);
      step(1, 0, 0, 0);       expect_out("t5.s6", 1, 0, scl(-5), scl(7));
      step(0, 0, 0, 0);       expect_out("t5.idle", 0, 0, 0, 0);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
